keypad_scanner: RTL and testbench

Upstream stage of the hex-keypad interface. Drives the four keypad columns one at a time and watches the four row lines. When a row goes low it debounces the press and latches the 2-bit column index and 2-bit row index. The key encoder consumes these indices (column index on bitcounter1/bitcounter2, row index on bitkey1/bitkey2) and produces key value row*4+col.

---
 rtl/keypad_scanner.sv | 149 ++++++++++++++
 tb/tb_keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning front end for a 4x4 hex keypad.
// Drives one column low at a time, synchronizes and debounces the row lines,
// and latches the column/row index of each accepted press for the key encoder.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] col_code,
    output logic [1:0] row_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Last dwell cycle of a column, and the count value that completes a debounce run.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [1:0]       col_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [1:0]       cand_row;
    logic             row_hit;
    logic [1:0]       row_sel;

    // One-cold column drive pattern for a column index.
    function automatic logic [3:0] drive(input logic [1:0] c);
        drive = ~(4'b0001 << c);
    endfunction

    // Two-flop synchronizer for the asynchronous row lines (idle = pulled high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= row_n;
            rs       <= row_meta;
        end
    end

    // Lowest-index active row wins when several are low together.
    always_comb begin
        row_hit = 1'b0;
        row_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) begin
                row_hit = 1'b1;
                row_sel = 2'(i);
            end
        end
    end

    // Scan / debounce / hold / release state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_cnt   <= 2'd0;
            col_n     <= 4'b1110;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            cand_row  <= 2'd0;
            col_code  <= 2'd0;
            row_code  <= 2'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (row_hit) begin
                            // Column stays frozen; the triggering sample counts as the first.
                            cand_row <= row_sel;
                            deb_cnt  <= '0;
                            state    <= ST_DEBOUNCE;
                        end else begin
                            col_cnt <= col_cnt + 2'd1;
                            col_n   <= drive(col_cnt + 2'd1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                ST_DEBOUNCE: begin
                    if (!rs[cand_row]) begin
                        if (deb_cnt == DEB_DONE) begin
                            col_code  <= col_cnt;
                            row_code  <= cand_row;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= ST_HELD;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Bounce: restart a full dwell on the same column.
                        div_cnt <= '0;
                        state   <= ST_SCAN;
                    end
                end

                ST_HELD: begin
                    if (rs[row_code]) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (rs == 4'b1111) begin
                        if (deb_cnt == DEB_DONE) begin
                            key_held <= 1'b0;
                            col_cnt  <= col_cnt + 2'd1;
                            col_n    <= drive(col_cnt + 2'd1);
                            div_cnt  <= '0;
                            state    <= ST_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        state <= ST_HELD;
                    end
                end

                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a 4x4 keypad matrix model.
module tb_keypad_scanner;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       row_n;
    logic [3:0]       col_n;
    logic [1:0]       col_code;
    logic [1:0]       row_code;
    logic             key_valid;
    logic             key_held;
    logic [3:0][3:0]  press;     // press[r][c]

    int compared   = 0;
    int mismatched = 0;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_n(row_n),
        .col_n(col_n),
        .col_code(col_code),
        .row_code(row_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad: row r pulled low when a pressed key in that row sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_n[r] = ~(|(press[r] & ~col_n));
    end

    // Wait for col_n to newly become target (arrives on the first dwell cycle).
    task automatic wait_col(input logic [3:0] target, output bit ok);
        bit left;
        ok   = 1'b0;
        left = (col_n !== target);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (col_n !== target) left = 1'b1;
            else if (left) ok = 1'b1;
        end
    endtask

    // Cycles until key_valid is seen, -1 on timeout.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Cycles until key_held drops, -1 on timeout; also counts key_valid pulses seen.
    task automatic wait_release(output int n, output int pulses);
        n      = -1;
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
            if (key_held === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        press = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (col_n !== 4'b1110) begin mismatched++; $display("FAIL reset_col_n got %b expected 1110", col_n); end
        compared++;
        if (col_code !== 2'd0 || row_code !== 2'd0) begin
            mismatched++; $display("FAIL reset_codes got %0d/%0d expected 0/0", col_code, row_code);
        end
        compared++;
        if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b expected 0", key_valid); end
        compared++;
        if (key_held !== 1'b0) begin mismatched++; $display("FAIL reset_held got %b expected 0", key_held); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] one = 4'b0001;
        logic [3:0] exp;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = ~(one << ((k / 4) % 4));
            compared++;
            if (col_n !== exp) begin
                mismatched++; $display("FAIL idle_col_n k=%0d got %b expected %b", k, col_n, exp);
            end
            compared++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                mismatched++; $display("FAIL idle_flags k=%0d got valid=%b held=%b expected 0/0", k, key_valid, key_held);
            end
        end
    endtask

    task automatic test_clean_press();
        int n, pulses;
        press[2][1] = 1'b1;           // column 1 just started its dwell
        wait_valid(n);
        compared++;
        if (n !== 11) begin mismatched++; $display("FAIL press_latency got %0d expected 11", n); end
        compared++;
        if (col_code !== 2'd1 || row_code !== 2'd2) begin
            mismatched++; $display("FAIL press_codes got %0d/%0d expected 1/2", col_code, row_code);
        end
        compared++;
        if (key_held !== 1'b1) begin mismatched++; $display("FAIL press_held got %b expected 1", key_held); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (key_valid !== 1'b0 || key_held !== 1'b1) begin
                mismatched++; $display("FAIL press_hold i=%0d got valid=%b held=%b expected 0/1", i, key_valid, key_held);
            end
        end
        press[2][1] = 1'b0;
        wait_release(n, pulses);
        compared++;
        if (n !== 10) begin mismatched++; $display("FAIL release_latency got %0d expected 10", n); end
        compared++;
        if (pulses !== 0) begin mismatched++; $display("FAIL release_pulses got %0d expected 0", pulses); end
        compared++;
        if (col_n !== 4'b1011) begin mismatched++; $display("FAIL release_next_col got %b expected 1011", col_n); end
        compared++;
        if (col_code !== 2'd1 || row_code !== 2'd2) begin
            mismatched++; $display("FAIL release_codes got %0d/%0d expected 1/2", col_code, row_code);
        end
    endtask

    task automatic test_bounce();
        bit ok;
        logic [3:0] exp;
        wait_col(4'b0111, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL bounce_wait_col got timeout expected col 3"); end
        press[0][3] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i < 10) ? 4'b0111 : 4'b1110;
            compared++;
            if (key_valid !== 1'b0) begin mismatched++; $display("FAIL bounce_valid i=%0d got %b expected 0", i, key_valid); end
            compared++;
            if (col_n !== exp) begin mismatched++; $display("FAIL bounce_col_n i=%0d got %b expected %b", i, col_n, exp); end
            if (i == 3) press[0][3] = 1'b0;
        end
        compared++;
        if (col_code !== 2'd1 || row_code !== 2'd2 || key_held !== 1'b0) begin
            mismatched++; $display("FAIL bounce_codes got %0d/%0d held=%b expected 1/2 held=0", col_code, row_code, key_held);
        end
    endtask

    task automatic test_multi_row();
        bit ok;
        int n, pulses;
        wait_col(4'b0111, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL multi_wait_col got timeout expected col 3"); end
        press[1][3] = 1'b1;
        press[3][3] = 1'b1;
        wait_valid(n);
        compared++;
        if (n !== 11) begin mismatched++; $display("FAIL multi_latency got %0d expected 11", n); end
        compared++;
        if (col_code !== 2'd3 || row_code !== 2'd1) begin
            mismatched++; $display("FAIL multi_codes got %0d/%0d expected 3/1", col_code, row_code);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
        end
        press[1][3] = 1'b0;
        press[3][3] = 1'b0;
        compared++;
        if (pulses !== 0) begin mismatched++; $display("FAIL multi_extra_pulses got %0d expected 0", pulses); end
        wait_release(n, pulses);
        compared++;
        if (n !== 10 || pulses !== 0) begin
            mismatched++; $display("FAIL multi_release got n=%0d pulses=%0d expected 10/0", n, pulses);
        end
    endtask

    task automatic test_release_glitch();
        bit ok;
        int n;
        logic exp_held;
        wait_col(4'b1011, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL glitch_wait_col got timeout expected col 2"); end
        press[2][2] = 1'b1;
        wait_valid(n);
        compared++;
        if (n !== 11) begin mismatched++; $display("FAIL glitch_latency got %0d expected 11", n); end
        compared++;
        if (col_code !== 2'd2 || row_code !== 2'd2) begin
            mismatched++; $display("FAIL glitch_codes got %0d/%0d expected 2/2", col_code, row_code);
        end
        repeat (3) @(negedge clk);
        press[2][2] = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_held = (i < 16);
            compared++;
            if (key_held !== exp_held || key_valid !== 1'b0) begin
                mismatched++; $display("FAIL glitch_release i=%0d got held=%b valid=%b expected %b/0", i, key_held, key_valid, exp_held);
            end
            if (i == 5) press[2][2] = 1'b1;
            if (i == 6) press[2][2] = 1'b0;
        end
        compared++;
        if (col_n !== 4'b0111) begin mismatched++; $display("FAIL glitch_next_col got %b expected 0111", col_n); end
    endtask

    task automatic test_reset_in_held();
        bit ok;
        int n;
        logic [3:0] exp;
        wait_col(4'b0111, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rsthold_wait_col got timeout expected col 3"); end
        press[3][3] = 1'b1;
        wait_valid(n);
        compared++;
        if (n !== 11 || col_code !== 2'd3 || row_code !== 2'd3) begin
            mismatched++; $display("FAIL rsthold_press got n=%0d codes=%0d/%0d expected 11 3/3", n, col_code, row_code);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (col_n !== 4'b1110) begin mismatched++; $display("FAIL rsthold_col_n got %b expected 1110", col_n); end
        compared++;
        if (col_code !== 2'd0 || row_code !== 2'd0) begin
            mismatched++; $display("FAIL rsthold_codes got %0d/%0d expected 0/0", col_code, row_code);
        end
        compared++;
        if (key_held !== 1'b0 || key_valid !== 1'b0) begin
            mismatched++; $display("FAIL rsthold_flags got held=%b valid=%b expected 0/0", key_held, key_valid);
        end
        press = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp = (i < 4) ? 4'b1110 : 4'b1101;
            compared++;
            if (col_n !== exp) begin mismatched++; $display("FAIL rsthold_rescan i=%0d got %b expected %b", i, col_n, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_multi_row();
        test_release_glitch();
        test_reset_in_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
